// File: rtl/issue_gate.sv
// One-entry issue holding register between decode and execute.
// Holds an instruction until its operands are ready, then hands it to execute and marks its destination busy.
module issue_gate #(
   parameter int unsigned STALL_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [15:0]        in_instr,
   input  logic [2:0]         in_sr1,
   input  logic [2:0]         in_sr2,
   input  logic [2:0]         in_dr,
   input  logic               in_sr1_used,
   input  logic               in_sr2_used,
   input  logic               in_dr_used,
   input  logic [7:0]         reg_ready,
   input  logic               wb_valid,
   input  logic [2:0]         wb_dr,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [15:0]        out_instr,
   output logic [2:0]         out_dr,
   output logic               out_dr_used,
   output logic               sb_busy_we,
   output logic [2:0]         sb_busy_idx,
   output logic [STALL_W-1:0] stall_count
);

   localparam int unsigned INSTR_W = 16;
   localparam int unsigned REG_W   = 3;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;

   logic [0:0]         state_q,    state_d;
   logic [INSTR_W-1:0] instr_q,    instr_d;
   logic [REG_W-1:0]   sr1_q,      sr1_d;
   logic [REG_W-1:0]   sr2_q,      sr2_d;
   logic [REG_W-1:0]   dr_q,       dr_d;
   logic               sr1_used_q, sr1_used_d;
   logic               sr2_used_q, sr2_used_d;
   logic               dr_used_q,  dr_used_d;
   logic [STALL_W-1:0] stall_q,    stall_d;

   logic sr1_ok;
   logic sr2_ok;
   logic dst_ok;
   logic ops_ok;
   logic holding;
   logic issue;
   logic accept;

   // Sources may be woken by a same-cycle writeback; the destination waits for the scoreboard.
   always_comb begin
      sr1_ok  = !sr1_used_q || reg_ready[sr1_q] || (wb_valid && (wb_dr == sr1_q));
      sr2_ok  = !sr2_used_q || reg_ready[sr2_q] || (wb_valid && (wb_dr == sr2_q));
      dst_ok  = !dr_used_q  || reg_ready[dr_q];
      ops_ok  = sr1_ok && sr2_ok && dst_ok;
      holding = (state_q == HOLD);
   end

   // Handshakes and next-state; reset and flush both suppress any transfer.
   always_comb begin
      out_valid   = 1'b0;
      in_ready    = 1'b0;
      issue       = 1'b0;
      accept      = 1'b0;
      sb_busy_we  = 1'b0;
      state_d     = state_q;
      instr_d     = instr_q;
      sr1_d       = sr1_q;
      sr2_d       = sr2_q;
      dr_d        = dr_q;
      sr1_used_d  = sr1_used_q;
      sr2_used_d  = sr2_used_q;
      dr_used_d   = dr_used_q;
      stall_d     = stall_q;

      out_valid  = holding && ops_ok && !flush && !reset;
      issue      = out_valid && out_ready;
      in_ready   = !reset && !flush && (!holding || issue);
      accept     = in_valid && in_ready;
      sb_busy_we = issue && dr_used_q;

      if (flush) begin
         state_d = IDLE;
      end else if (accept) begin
         state_d    = HOLD;
         instr_d    = in_instr;
         sr1_d      = in_sr1;
         sr2_d      = in_sr2;
         dr_d       = in_dr;
         sr1_used_d = in_sr1_used;
         sr2_used_d = in_sr2_used;
         dr_used_d  = in_dr_used;
      end else if (issue) begin
         state_d = IDLE;
      end

      // Operand stalls only; back-pressure from execute is not counted.
      if (holding && !ops_ok && !flush && !(&stall_q)) begin
         stall_d = stall_q + STALL_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         instr_q    <= '0;
         sr1_q      <= '0;
         sr2_q      <= '0;
         dr_q       <= '0;
         sr1_used_q <= 1'b0;
         sr2_used_q <= 1'b0;
         dr_used_q  <= 1'b0;
         stall_q    <= '0;
      end else begin
         state_q    <= state_d;
         instr_q    <= instr_d;
         sr1_q      <= sr1_d;
         sr2_q      <= sr2_d;
         dr_q       <= dr_d;
         sr1_used_q <= sr1_used_d;
         sr2_used_q <= sr2_used_d;
         dr_used_q  <= dr_used_d;
         stall_q    <= stall_d;
      end
   end

   assign out_instr   = instr_q;
   assign out_dr      = dr_q;
   assign out_dr_used = dr_used_q;
   assign sb_busy_idx = dr_q;
   assign stall_count = stall_q;

endmodule

// File: doc/issue_gate.md
ISSUE_GATE -- requirements
Module: issue_gate

Interface
REQ-001 Parameter STALL_W, default 8, width of the stall-cycle counter.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  decode stage presents an instruction.
REQ-005 in_ready  output  1  issue_gate accepts the presented instruction this edge.
REQ-006 in_instr  input  16  instruction payload (lc3b_word).
REQ-007 in_sr1, in_sr2, in_dr  input  3 each  source/destination register indices (lc3b_reg).
REQ-008 in_sr1_used, in_sr2_used, in_dr_used  input  1 each  operand-valid flags.
REQ-009 reg_ready  input  8  scoreboard readiness vector, 1 = register value available.
REQ-010 wb_valid  input  1  writeback retires a register this cycle; wb_dr  input  3  its index.
REQ-011 flush  input  1  discard held instruction (branch redirect).
REQ-012 out_valid  output  1  held instruction is issuable; out_ready  input  1  execute accepts.
REQ-013 out_instr  output  16; out_dr  output  3; out_dr_used  output  1  held payload.
REQ-014 sb_busy_we  output  1; sb_busy_idx  output  3  mark-busy request to scoreboard (its write0/index0).
REQ-015 stall_count  output  STALL_W  saturating count of operand-stall cycles.

Function
REQ-016 One-entry holding register; FSM states IDLE (empty) and HOLD (instruction held).
REQ-017 src_ok(s) = !used || reg_ready[s] || (wb_valid && wb_dr == s); same-cycle writeback wakes a source.
REQ-018 dst_ok = !in_dr_used(held) || reg_ready[dr]; destination uses reg_ready only, no wb bypass.
REQ-019 ops_ok = src_ok(sr1) && src_ok(sr2) && dst_ok, evaluated on held fields, combinationally.
REQ-020 out_valid = (state == HOLD) && ops_ok && !flush.
REQ-021 issue = out_valid && out_ready.
REQ-022 sb_busy_we = issue && held dr_used; sb_busy_idx = held dr (scoreboard shows busy from next cycle).
REQ-023 in_ready = !flush && (state == IDLE || issue).
REQ-024 IDLE -> HOLD when in_valid && in_ready; all in_* fields latched that edge.
REQ-025 HOLD -> HOLD with new payload when issue && in_valid (back-to-back, no bubble).
REQ-026 HOLD -> IDLE when issue && !in_valid.
REQ-027 flush has priority: state -> IDLE, no issue, no sb_busy_we, incoming instruction not accepted.
REQ-028 HOLD && !ops_ok && !flush: instruction held, fields unchanged, in_ready = 0.
REQ-029 stall_count += 1 each cycle state == HOLD && !ops_ok && !flush; saturates at 2^STALL_W-1, no wrap.
REQ-030 HOLD && ops_ok && !out_ready is back-pressure, not a stall; stall_count unchanged.
REQ-031 Issue order equals acceptance order; at most one issue per cycle.

Reset
REQ-032 reset has priority over flush and all handshakes; takes effect at the next rising edge.
REQ-033 After reset: state IDLE, out_valid 0, sb_busy_we 0, out_instr 16'h0000, out_dr 0, out_dr_used 0, stall_count 0, in_ready 1 (flush low).
REQ-034 reset during HOLD discards the held instruction without any sb_busy_we.

Verification
REQ-035 reg_ready=8'hFF, accept sr1=1,sr2=2,dr=3, out_ready=1 -> out_valid next cycle, sb_busy_we=1, sb_busy_idx=3, state IDLE after.
REQ-036 reg_ready[4]=0, held sr1=4 for 3 cycles, then wb_valid=1,wb_dr=4 -> issues in the wb cycle, stall_count=3.
REQ-037 held dr=5, reg_ready[5]=0, wb_valid=1,wb_dr=5 -> no issue that cycle; issues next cycle once reg_ready[5]=1.
REQ-038 flush=1 while HOLD and in_valid=1 -> in_ready=0, no sb_busy_we, state IDLE, out_valid=0 next cycle.
REQ-039 in_valid held high, reg_ready=8'hFF, out_ready=1 for 4 cycles -> 4 issues on 4 consecutive cycles, no bubble.
REQ-040 STALL_W=2, operand stall 6 cycles -> stall_count saturates at 3; reset -> 0.
